// File: rtl/ps2_key_capture_if.sv
// PS/2 line inputs and key-event outputs of ps2_key_capture, bundled for the
// edit-control logic. master = capture block, slave = consumer / bench.
interface ps2_key_capture_if #(
   parameter int N = 8
);
   // ps2_clk/ps2_data are raw asynchronous lines. got_code_tick is a valid-only
   // strobe with no ready: key_code/extended are valid in the tick cycle and
   // held afterwards; a consumer that is not looking simply misses the event.
   logic         ps2_clk;
   logic         ps2_data;
   logic [N-1:0] key_code;
   logic         got_code_tick;
   logic         extended;
   logic         parity_err;

   modport master (
      input  ps2_clk,
      input  ps2_data,
      output key_code,
      output got_code_tick,
      output extended,
      output parity_err
   );

   modport slave (
      output ps2_clk,
      output ps2_data,
      input  key_code,
      input  got_code_tick,
      input  extended,
      input  parity_err
   );
endinterface

// File: rtl/ps2_key_capture.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, E0/F0 prefix
// stripping. Define PS2_PARITY_CHECK_EN to enforce odd parity and pulse parity_err.
module ps2_key_capture #(
   parameter int N           = 8,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic              clk,
   input  logic              rst,
   ps2_key_capture_if.master bus,
   output logic [1:0]        state_dbg
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   // ------------------------------------------------------------------
   // Synchronisers and clock glitch filter
   // ------------------------------------------------------------------
   logic                  clk_s1, clk_s2;
   logic                  data_s1, data_s2;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  filt_clk;
   logic                  fall;
   logic                  sr_zero, sr_one;

   assign sr_zero = (filt_sr == '0);
   assign sr_one  = (filt_sr == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
         filt_sr  <= '1;
         filt_clk <= 1'b1;
         fall     <= 1'b0;
      end else begin
         clk_s1   <= bus.ps2_clk;
         clk_s2   <= clk_s1;
         data_s1  <= bus.ps2_data;
         data_s2  <= data_s1;
         filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_s2};
         // The edge pulse is registered in the same cycle filt_clk drops.
         fall     <= filt_clk & sr_zero;
         if (sr_zero)
            filt_clk <= 1'b0;
         else if (sr_one)
            filt_clk <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   frame_state_t state, state_n;
   logic [2:0]   bit_cnt, bit_cnt_n;
   logic [N-1:0] shift, shift_n;
   logic [TW-1:0] tmo, tmo_n;
   logic         accept, accept_n;
`ifdef PS2_PARITY_CHECK_EN
   logic         par_bit, par_bit_n;
   logic         bad_par, bad_par_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         tmo     <= '0;
         accept  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par_bit <= 1'b0;
         bad_par <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         shift   <= shift_n;
         tmo     <= tmo_n;
         accept  <= accept_n;
`ifdef PS2_PARITY_CHECK_EN
         par_bit <= par_bit_n;
         bad_par <= bad_par_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      accept_n  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit_n = par_bit;
      bad_par_n = 1'b0;
`endif
      if (state == IDLE || fall)
         tmo_n = '0;
      else
         tmo_n = tmo + 1'b1;

      if (fall) begin
         case (state)
            IDLE: begin
               if (!data_s2) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               shift_n   = {data_s2, shift[N-1:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'(N - 1))
                  state_n = PARITY;
            end
            PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_bit_n = data_s2;
`endif
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               // A bad stop bit drops the frame silently, before parity is considered.
               if (data_s2) begin
`ifdef PS2_PARITY_CHECK_EN
                  if (^{shift, par_bit})
                     accept_n = 1'b1;
                  else
                     bad_par_n = 1'b1;
`else
                  accept_n = 1'b1;
`endif
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE && tmo == TW'(TIMEOUT_CYC)) begin
         state_n = IDLE;
      end
   end

   assign state_dbg = state;

   // ------------------------------------------------------------------
   // Prefix decoder and event outputs
   // ------------------------------------------------------------------
   logic ext_flag, brk_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_flag          <= 1'b0;
         brk_flag          <= 1'b0;
         bus.key_code      <= '0;
         bus.extended      <= 1'b0;
         bus.got_code_tick <= 1'b0;
      end else begin
         bus.got_code_tick <= 1'b0;
         if (accept) begin
            if (shift == BYTE_EXT) begin
               ext_flag <= 1'b1;
            end else if (shift == BYTE_BRK) begin
               brk_flag <= 1'b1;
            end else if (brk_flag) begin
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end else begin
               bus.key_code      <= shift;
               bus.extended      <= ext_flag;
               bus.got_code_tick <= 1'b1;
               ext_flag          <= 1'b0;
               brk_flag          <= 1'b0;
            end
         end
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         bus.parity_err <= 1'b0;
      else
         bus.parity_err <= bad_par;
   end
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_capture.sv
// Self-checking bench for ps2_key_capture: PS/2 frame driver, expected-event
// scoreboard, latency/exclusivity monitor and one summary line.
module tb_ps2_key_capture;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 200;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         stop_cyc = 0;
  int         pe_seen  = 0;
  int         pe_exp   = 0;
  logic [8:0] exp_q[$];

  ps2_key_capture_if #(.N(8)) bus ();

  ps2_key_capture #(
    .N(8),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: 40-cycle bit period, data changes mid-high phase
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input int glitch_bit);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      wait_cyc(10);
      if (i == 10) stop_cyc = cyc + 1;
      bus.ps2_clk = 1'b0;
      wait_cyc(20);
      bus.ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        wait_cyc(10);
        bus.ps2_clk = 1'b0;
        wait_cyc(2);
        bus.ps2_clk = 1'b1;
        wait_cyc(8);
      end else begin
        wait_cyc(10);
      end
    end
    wait_cyc(60);
  endtask

  task automatic push_exp(input logic ext, input logic [7:0] code);
    exp_q.push_back({ext, code});
  endtask

  task automatic drain(input string tag);
    wait_cyc(30);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_perr_cnt"}, pe_seen, pe_exp);
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (bus.got_code_tick || bus.parity_err)
        check("tick_perr_excl", bus.got_code_tick & bus.parity_err, 0);
      if (bus.parity_err) pe_seen++;
      if (bus.got_code_tick) begin
        check("tick_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("key_code", bus.key_code, e[7:0]);
          check("extended", bus.extended, e[8]);
          check("latency", cyc - stop_cyc, FILTER_LEN + 4);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cyc(5);
    check("rst_key_code", bus.key_code, 0);
    check("rst_extended", bus.extended, 0);
    check("rst_tick", bus.got_code_tick, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    wait_cyc(20);

    // plain make code
    push_exp(1'b0, 8'h74);
    send_frame(8'h74, 1'b0, 11, -1);
    drain("make74");

    // extended make, then plain make
    push_exp(1'b1, 8'h6B);
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'h6B, 1'b0, 11, -1);
    push_exp(1'b0, 8'h74);
    send_frame(8'h74, 1'b0, 11, -1);
    drain("ext6b");

    // break sequences produce nothing and leave flags clear
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h74, 1'b0, 11, -1);
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h6B, 1'b0, 11, -1);
    drain("break");
    check("break_key_hold", bus.key_code, 8'h74);
    push_exp(1'b0, 8'h74);
    send_frame(8'h74, 1'b0, 11, -1);
    drain("after_break");

    // bad parity, alone and between E0 and a make code
`ifdef PS2_PARITY_CHECK_EN
    pe_exp++;
    send_frame(8'h74, 1'b1, 11, -1);
    pe_exp++;
    push_exp(1'b1, 8'h6B);
`else
    push_exp(1'b0, 8'h74);
    send_frame(8'h74, 1'b1, 11, -1);
    push_exp(1'b1, 8'h74);
    push_exp(1'b0, 8'h6B);
`endif
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'h74, 1'b1, 11, -1);
    send_frame(8'h6B, 1'b0, 11, -1);
    drain("parity");

    // partial frame abandoned by timeout
    send_frame(8'h55, 1'b0, 5, -1);
    check("partial_busy", (state_dbg != 0), 1);
    wait_cyc(250);
    check("timeout_idle", state_dbg, 0);
    push_exp(1'b0, 8'h6B);
    send_frame(8'h6B, 1'b0, 11, -1);
    drain("timeout");

    // short clock glitch mid-frame
    push_exp(1'b0, 8'h74);
    send_frame(8'h74, 1'b0, 11, 4);
    drain("glitch");

    // reset during data bits
    bus.ps2_data = 1'b0;
    send_frame(8'h33, 1'b0, 4, -1);
    rst = 1'b1;
    wait_cyc(1);
    check("midrst_key_code", bus.key_code, 0);
    check("midrst_extended", bus.extended, 0);
    check("midrst_tick", bus.got_code_tick, 0);
    check("midrst_perr", bus.parity_err, 0);
    check("midrst_state", state_dbg, 0);
    rst = 1'b0;
    bus.ps2_data = 1'b1;
    wait_cyc(250);
    push_exp(1'b0, 8'h74);
    send_frame(8'h74, 1'b0, 11, -1);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
